// File: rtl/stopwatch_pkg.sv
// Shared types and BCD limits for the stopwatch timekeeper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // Packs a decimal limit (0..99) into two BCD digits {tens, units}.
    function automatic logic [7:0] to_bcd2(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps MAX->00 and flags the wrap on carry.
module bcd2_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] count,
    output logic       carry
);

    localparam logic [7:0] MAX_BCD = to_bcd2(MAX);

    logic [7:0] r_cnt;
    logic       w_at_max;

    assign w_at_max = (r_cnt == MAX_BCD);
    assign carry    = en && w_at_max;
    assign count    = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'h00;
        end else if (clr) begin
            r_cnt <= 8'h00;
        end else if (en) begin
            if (w_at_max) begin
                r_cnt <= 8'h00;
            end else if (r_cnt[3:0] == 4'd9) begin
                r_cnt <= {r_cnt[7:4] + 4'd1, 4'd0};
            end else begin
                r_cnt <= {r_cnt[7:4], r_cnt[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// BCD stopwatch: run/pause/clear FSM, 100 Hz prescaler and cs/s/min chain.
// Optional display freeze (lap hold) is built when STOPWATCH_LAP_EN is defined.
//
// state    | meaning
// ST_IDLE  | stopped, prescaler held at zero
// ST_RUN   | prescaler advancing, counts increment on each tick
// ST_PAUSE | counts and prescaler frozen, resume continues mid-tick
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [7:0] out_ms,
    output logic [7:0] out_s,
    output logic [7:0] out_min,
    output logic       running,
    output logic       ovf
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    sw_state_t        r_state;
    sw_state_t        w_state_nxt;
    logic [PRE_W-1:0] r_pre;
    logic             r_ovf;
    logic             w_tick;
    logic             w_cs_carry;
    logic             w_sec_carry;
    logic             w_min_carry;
    logic [7:0]       w_cs;
    logic [7:0]       w_sec;
    logic [7:0]       w_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (start_stop) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_tick = (r_state == ST_RUN) && (r_pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (clear || r_state == ST_IDLE) begin
            r_pre <= '0;
        end else if (r_state == ST_RUN) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
        end
    end

    bcd2_counter #(.MAX(CS_MAX)) u_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_tick),
        .clr   (clear),
        .count (w_cs),
        .carry (w_cs_carry)
    );

    bcd2_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_cs_carry),
        .clr   (clear),
        .count (w_sec),
        .carry (w_sec_carry)
    );

    bcd2_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_sec_carry),
        .clr   (clear),
        .count (w_min),
        .carry (w_min_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_ovf <= 1'b0;
        end else if (w_min_carry) begin
            r_ovf <= 1'b1;
        end
    end

    assign running = (r_state == ST_RUN);
    assign ovf     = r_ovf;

`ifdef STOPWATCH_LAP_EN
    logic        r_frozen;
    logic [23:0] r_hold;

    // Capture takes the count as it stands before this edge's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frozen <= 1'b0;
            r_hold   <= 24'h000000;
        end else if (clear) begin
            r_frozen <= 1'b0;
        end else if (lap) begin
            if (r_frozen) begin
                r_frozen <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_frozen <= 1'b1;
                r_hold   <= {w_min, w_sec, w_cs};
            end
        end
    end

    assign out_min = r_frozen ? r_hold[23:16] : w_min;
    assign out_s   = r_frozen ? r_hold[15:8]  : w_sec;
    assign out_ms  = r_frozen ? r_hold[7:0]   : w_cs;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;

    assign out_min = w_min;
    assign out_s   = w_sec;
    assign out_ms  = w_cs;
`endif

endmodule
